// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: drives en/clear for PC, IF/ID, ID/EX, EX/MEM, MEM/WB
// from exception, memory wait, multi-cycle divide and load-use sources.
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 36,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic        mem_stall,
    input  logic        ex_div_start,
    input  logic        ex_memtoreg,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_wreg,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    output logic        pc_en,
    output logic        f_d_en,
    output logic        f_d_clear,
    output logic        d_e_en,
    output logic        d_e_clear,
    output logic        e_m_en,
    output logic        e_m_clear,
    output logic        m_w_en,
    output logic        m_w_clear,
    output logic        div_busy,
    output logic        div_done,
    output logic        div_cancel,
    output logic [31:0] stall_cycles,
    output logic        state_dbg
);

    typedef enum logic {RUN = 1'b0, DIV = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        stall_cycles_q, stall_cycles_d;
    logic               load_use;
    logic               div_stall;

    assign load_use  = (state_q == RUN) && ex_memtoreg && ex_regwrite && (ex_wreg != 5'd0) &&
                       ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    assign div_stall = ((state_q == RUN) && ex_div_start) || ((state_q == DIV) && (cnt_q != '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_valid) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (mem_stall) begin
            // Divide progress freezes; a pending release waits for the memory.
            state_d = state_q;
            cnt_d   = cnt_q;
        end else if ((state_q == RUN) && ex_div_start) begin
            state_d = DIV;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end else if (state_q == DIV) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        f_d_en     = 1'b1;
        f_d_clear  = 1'b0;
        d_e_en     = 1'b1;
        d_e_clear  = 1'b0;
        e_m_en     = 1'b1;
        e_m_clear  = 1'b0;
        m_w_en     = 1'b1;
        m_w_clear  = 1'b0;
        div_done   = 1'b0;
        div_cancel = 1'b0;
        if (!reset) begin
            pc_en     = 1'b0;
            f_d_en    = 1'b0;
            d_e_en    = 1'b0;
            e_m_en    = 1'b0;
            m_w_en    = 1'b0;
            f_d_clear = 1'b1;
            d_e_clear = 1'b1;
            e_m_clear = 1'b1;
            m_w_clear = 1'b1;
        end else if (exc_valid) begin
            f_d_clear  = 1'b1;
            d_e_clear  = 1'b1;
            e_m_clear  = 1'b1;
            m_w_clear  = 1'b1;
            div_cancel = (state_q == DIV);
        end else if (mem_stall) begin
            pc_en     = 1'b0;
            f_d_en    = 1'b0;
            d_e_en    = 1'b0;
            e_m_en    = 1'b0;
            m_w_clear = 1'b1;
        end else if (div_stall) begin
            pc_en     = 1'b0;
            f_d_en    = 1'b0;
            d_e_en    = 1'b0;
            e_m_clear = 1'b1;
        end else if (state_q == DIV) begin
            div_done = 1'b1;
        end else if (load_use) begin
            pc_en     = 1'b0;
            f_d_en    = 1'b0;
            d_e_clear = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    assign div_busy     = reset && (state_q == DIV);
    assign state_dbg    = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model of the stall/flush priority rules.
module tb_pipe_stall_ctrl;

    localparam int DIV_CYCLES = 36;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid, mem_stall, ex_div_start, ex_memtoreg, ex_regwrite;
    logic [4:0]  ex_wreg, id_rs, id_rt;
    logic        pc_en, f_d_en, f_d_clear, d_e_en, d_e_clear, e_m_en, e_m_clear;
    logic        m_w_en, m_w_clear, div_busy, div_done, div_cancel, state_dbg;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_div;
    int          m_stalls_done;
    logic [31:0] m_sc;

    logic [12:0] obs, exp_v;
    logic [31:0] sc0;

    pipe_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .exc_valid(exc_valid), .mem_stall(mem_stall),
        .ex_div_start(ex_div_start), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .ex_wreg(ex_wreg), .id_rs(id_rs), .id_rt(id_rt),
        .pc_en(pc_en), .f_d_en(f_d_en), .f_d_clear(f_d_clear),
        .d_e_en(d_e_en), .d_e_clear(d_e_clear), .e_m_en(e_m_en), .e_m_clear(e_m_clear),
        .m_w_en(m_w_en), .m_w_clear(m_w_clear), .div_busy(div_busy), .div_done(div_done),
        .div_cancel(div_cancel), .stall_cycles(stall_cycles), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic quiet();
        exc_valid = 0; mem_stall = 0; ex_div_start = 0; ex_memtoreg = 0; ex_regwrite = 0;
        ex_wreg = 0; id_rs = 0; id_rt = 0;
    endtask

    task automatic rand_inputs();
        exc_valid    = ($urandom_range(0, 15) == 0);
        mem_stall    = ($urandom_range(0, 7) == 0);
        ex_div_start = ($urandom_range(0, 15) == 0);
        ex_memtoreg  = 1'($urandom_range(0, 1));
        ex_regwrite  = 1'($urandom_range(0, 1));
        ex_wreg      = 5'($urandom_range(0, 3));
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
    endtask

    // Called at a falling edge with inputs applied; checks, then advances one cycle.
    task automatic cycle();
        bit pc, fde, fdc, dee, dec, eme, emc, mwe, mwc, bsy, dn, cn, lu;
        #1;
        pc = 1; fde = 1; fdc = 0; dee = 1; dec = 0; eme = 1; emc = 0; mwe = 1; mwc = 0;
        dn = 0; cn = 0;
        lu = !m_div && ex_memtoreg && ex_regwrite && ex_wreg != 0 &&
             (ex_wreg == id_rs || ex_wreg == id_rt);
        if (!reset) begin
            pc = 0; fde = 0; dee = 0; eme = 0; mwe = 0;
            fdc = 1; dec = 1; emc = 1; mwc = 1;
        end else if (exc_valid) begin
            fdc = 1; dec = 1; emc = 1; mwc = 1; cn = m_div;
        end else if (mem_stall) begin
            pc = 0; fde = 0; dee = 0; eme = 0; mwc = 1;
        end else if ((!m_div && ex_div_start) || (m_div && m_stalls_done < DIV_CYCLES)) begin
            pc = 0; fde = 0; dee = 0; emc = 1;
        end else if (m_div) begin
            dn = 1;
        end else if (lu) begin
            pc = 0; fde = 0; dec = 1;
        end
        bsy = reset && m_div;
        exp_v = {pc, fde, fdc, dee, dec, eme, emc, mwe, mwc, bsy, dn, cn, m_div};
        obs   = {pc_en, f_d_en, f_d_clear, d_e_en, d_e_clear, e_m_en, e_m_clear,
                 m_w_en, m_w_clear, div_busy, div_done, div_cancel, state_dbg};
        check("outs", 32'(obs), 32'(exp_v));
        check("stall_cycles", stall_cycles, m_sc);
        @(posedge clk);
        if (!reset) begin
            m_div = 0; m_stalls_done = 0; m_sc = 0;
        end else begin
            if (!pc && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (exc_valid) m_div = 0;
            else if (mem_stall) m_div = m_div;
            else if (!m_div && ex_div_start) begin
                m_div = 1; m_stalls_done = 1;
            end else if (m_div) begin
                if (m_stalls_done < DIV_CYCLES) m_stalls_done++;
                else m_div = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        quiet();
        reset = 0;
        m_div = 0; m_stalls_done = 0; m_sc = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with random inputs
        repeat (3) begin
            rand_inputs();
            cycle();
        end
        reset = 1;
        quiet();
        cycle();

        // Load-use on rt, then the load has moved on; then r0 destination
        ex_memtoreg = 1; ex_regwrite = 1; ex_wreg = 8; id_rt = 8; id_rs = 3;
        cycle();
        quiet();
        cycle();
        ex_memtoreg = 1; ex_regwrite = 1; ex_wreg = 0; id_rt = 0; id_rs = 0;
        cycle();
        quiet();

        // Plain divide: 36 stalls then release
        sc0 = stall_cycles;
        ex_div_start = 1;
        cycle();
        ex_div_start = 0;
        repeat (DIV_CYCLES) cycle();
        check("div_release_done", 32'(obs[2]), 32'd1);
        check("div_stall_total", stall_cycles - sc0, 32'd36);
        cycle();

        // Divide with 5 cycles of memory stall in the middle
        sc0 = stall_cycles;
        ex_div_start = 1;
        cycle();
        ex_div_start = 0;
        repeat (10) cycle();
        mem_stall = 1;
        repeat (5) cycle();
        mem_stall = 0;
        repeat (26) cycle();
        check("divms_release_done", 32'(obs[2]), 32'd1);
        check("divms_stall_total", stall_cycles - sc0, 32'd41);

        // Exception while divide has 10 left
        ex_div_start = 1;
        cycle();
        ex_div_start = 0;
        repeat (25) cycle();
        exc_valid = 1;
        mem_stall = 1;
        cycle();
        check("exc_cancel", 32'(obs[1]), 32'd1);
        check("exc_pc_en", 32'(obs[12]), 32'd1);
        quiet();
        cycle();
        check("exc_after_busy", 32'(obs[3]), 32'd0);
        check("exc_after_done", 32'(obs[2]), 32'd0);

        // Random traffic with occasional reset
        repeat (400) begin
            rand_inputs();
            reset = ($urandom_range(0, 63) != 0);
            cycle();
        end
        reset = 1;
        quiet();
        cycle();
        cycle();

        // Saturation of the stall counter
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        release dut.stall_cycles_q;
        m_sc = 32'hFFFF_FFFE;
        mem_stall = 1;
        repeat (3) cycle();
        check("sat_value", stall_cycles, 32'hFFFF_FFFF);
        cycle();
        mem_stall = 0;
        cycle();
        check("sat_hold", stall_cycles, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Each register is an enable/clear flop stage; this block drives every stage's en and clear.
- It arbitrates four stall and flush sources: exception, data-memory wait, multi-cycle divide, and load-use.
- Divide occupancy is tracked with an internal FSM and counter. A saturating stall-cycle performance counter is also kept.

Parameters:
DIV_CYCLES, 36, total EX-stage stall cycles for one divide (legal range 2..63)
CNT_W, 6, width of divide countdown counter (must hold DIV_CYCLES-1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
exc_valid  in  1  exception raised by instruction in MEM
mem_stall  in  1  data memory not ready for instruction in MEM
ex_div_start  in  1  EX holds a divide instruction
ex_memtoreg  in  1  EX instruction is a load
ex_regwrite  in  1  EX instruction writes a register
ex_wreg  in  5  EX destination register
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
pc_en  out  1  PC enable
f_d_en, f_d_clear  out  1 each  IF/ID enable / clear
d_e_en, d_e_clear  out  1 each  ID/EX enable / clear
e_m_en, e_m_clear  out  1 each  EX/MEM enable / clear
m_w_en, m_w_clear  out  1 each  MEM/WB enable / clear
div_busy  out  1  divide occupying EX (state DIV)
div_done  out  1  one-cycle pulse: divide result valid, EX released
div_cancel  out  1  abort in-flight divider
stall_cycles  out  32  count of cycles with pc_en=0, saturating

Behaviour:
- States: RUN, DIV. Registers: state, cnt[CNT_W], stall_cycles.
- reset low at a clock edge: state<=RUN, cnt<=0, stall_cycles<=0.
- While reset is low, outputs are forced: all *_en=0, all *_clear=1, div_done=0, div_cancel=0, div_busy=0.
- Default, with no condition active: all en=1, all clear=0.
- Priority is exc > mem_stall > divide > load-use. Only the highest active condition drives outputs.
- Exception (exc_valid=1):
  - all en=1; f_d_clear, d_e_clear, e_m_clear, m_w_clear=1; pc_en=1 (PC loads the vector, muxed elsewhere).
  - If state=DIV: div_cancel=1, state<=RUN, cnt<=0.
  - The exception also overrides mem_stall in the same cycle.
- Mem stall (mem_stall=1, exc_valid=0):
  - pc_en, f_d_en, d_e_en, e_m_en=0; m_w_en=1, m_w_clear=1 (bubble into WB).
  - Divide counter frozen. div_done is suppressed and deferred until mem_stall drops.
- Divide:
  - In RUN with ex_div_start=1 and no higher condition: state<=DIV, cnt<=DIV_CYCLES-1. This cycle is stalled.
  - In DIV with cnt!=0 and no higher condition: stalled, cnt<=cnt-1.
  - In DIV with cnt==0: div_done=1, no stall (e_m_en=1 captures the result), state<=RUN.
  - "Stalled" means: pc_en, f_d_en, d_e_en=0; e_m_clear=1.
  - ex_div_start is ignored while in DIV.
  - Net effect: exactly DIV_CYCLES stalled cycles, then the release cycle.
- Load-use, purely combinational:
  - Hazard when state=RUN, ex_memtoreg=1, ex_regwrite=1, ex_wreg!=0 and (ex_wreg==id_rs or ex_wreg==id_rt).
  - Response: pc_en=0, f_d_en=0, d_e_clear=1.
  - Lasts one cycle naturally, since the load advances.
  - If ex_div_start and a load-use hazard are both asserted, the divide wins. They cannot both be true for a legal instruction.
- div_busy = (state==DIV).
- stall_cycles increments each cycle pc_en=0 with reset high. It holds at 0xFFFFFFFF.
- All outputs other than stall_cycles, div_busy and state are combinational from inputs and state. There are no combinational input-to-input loops.
- Counter wrap is impossible by construction. cnt is never decremented below 0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all en=0, clears=1, stall_cycles=0, div_busy=0. Release -> default en=1, clears=0.
- Load-use: ex_memtoreg=1, ex_regwrite=1, ex_wreg=8, id_rt=8 -> one cycle of pc_en=0, f_d_en=0, d_e_clear=1. Repeat with ex_wreg=0 -> no stall.
- Divide, DIV_CYCLES=36: pulse ex_div_start -> pc_en=0 for exactly 36 cycles, e_m_clear=1 throughout, div_done=1 on cycle 37, then RUN. stall_cycles=36.
- Divide plus mem_stall: assert mem_stall for 5 cycles mid-divide -> cnt frozen, m_w_clear=1 during the stall. div_done arrives 5 cycles later, total 41 stalled cycles.
- Exception during DIV at cnt=10 -> same cycle div_cancel=1, all four clears=1, pc_en=1. Next cycle state=RUN, div_busy=0, no div_done.
- Saturation: preload or force stall_cycles=0xFFFFFFFE, stall 3 cycles -> reads 0xFFFFFFFF and holds.
